// File: rtl/console_ctrl.sv
// Scrolling text-terminal sequencer: pops keyboard codes and drives glyph, colour,
// scroll-offset and cursor writes into the VGA text memory.
module console_ctrl #(
  parameter int unsigned COLS      = 70,
  parameter int unsigned VIS_ROWS  = 30,
  parameter logic [2:0]  DEF_COLOR = 3'b111
) (
  input  logic        clk,
  input  logic        rst,
  output logic        key_rd,
  input  logic [7:0]  key_data,
  output logic        vga_en,
  output logic        vga_color_en,
  output logic        vga_offset_en,
  output logic        vga_cursor_en,
  output logic [31:0] vga_wraddr,
  output logic [7:0]  vga_wdata,
  output logic [11:0] cursor_data,
  output logic        busy
);

  localparam int unsigned CW       = 14;
  localparam int unsigned INIT_LEN = 2 * COLS * 32;
  localparam int unsigned CLR_LAST = 2 * COLS - 1;
  localparam logic [7:0]  BLANK    = 8'h20;

  typedef enum logic [3:0] {
    S_INIT, S_INIT_OFS, S_IDLE, S_FETCH, S_WR_CHAR, S_WR_COLOR, S_NEWLINE,
    S_SCROLL, S_CLEAR, S_BKSP, S_BK_GLYPH, S_BK_COLOR, S_CURSOR
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic [4:0]    offset_q, offset_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    code_q, code_d;
  logic [4:0]    phys_d;
  logic [12:0]   init_idx;

  logic          key_rd_d, vga_en_d, color_en_d, offset_en_d, cursor_en_d, busy_d;
  logic [31:0]   wraddr_d;
  logic [7:0]    wdata_d;
  logic [11:0]   cursor_data_d;

  // State, position and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_INIT;
      col_q         <= '0;
      row_q         <= '0;
      offset_q      <= '0;
      cnt_q         <= '0;
      code_q        <= '0;
      key_rd        <= 1'b0;
      vga_en        <= 1'b0;
      vga_color_en  <= 1'b0;
      vga_offset_en <= 1'b0;
      vga_cursor_en <= 1'b0;
      vga_wraddr    <= '0;
      vga_wdata     <= '0;
      cursor_data   <= '0;
      busy          <= 1'b1;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      offset_q      <= offset_d;
      cnt_q         <= cnt_d;
      code_q        <= code_d;
      key_rd        <= key_rd_d;
      vga_en        <= vga_en_d;
      vga_color_en  <= color_en_d;
      vga_offset_en <= offset_en_d;
      vga_cursor_en <= cursor_en_d;
      vga_wraddr    <= wraddr_d;
      vga_wdata     <= wdata_d;
      cursor_data   <= cursor_data_d;
      busy          <= busy_d;
    end
  end

  // Next state, then outputs decoded from the next state so they line up with it
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    offset_d      = offset_q;
    cnt_d         = cnt_q;
    code_d        = code_q;
    key_rd_d      = 1'b0;
    vga_en_d      = 1'b0;
    color_en_d    = 1'b0;
    offset_en_d   = 1'b0;
    cursor_en_d   = 1'b0;
    wraddr_d      = vga_wraddr;
    wdata_d       = vga_wdata;
    cursor_data_d = cursor_data;

    case (state_q)
      S_INIT: begin
        // cnt counts strobes already issued; the first INIT cycle after reset is silent
        if (cnt_q == CW'(INIT_LEN)) state_d = S_INIT_OFS;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      S_INIT_OFS: state_d = S_CURSOR;
      S_IDLE:     state_d = S_FETCH;
      S_FETCH: begin
        code_d = key_data;
        if (key_data >= 8'h20 && key_data <= 8'h7E)    state_d = S_WR_CHAR;
        else if (key_data == 8'h0D || key_data == 8'h0A) state_d = S_NEWLINE;
        else if (key_data == 8'h08)                    state_d = S_BKSP;
        else                                           state_d = S_IDLE;
      end
      S_WR_CHAR: state_d = S_WR_COLOR;
      S_WR_COLOR: begin
        if (col_q < 7'(COLS - 1)) begin
          col_d   = col_q + 7'd1;
          state_d = S_CURSOR;
        end else begin
          state_d = S_NEWLINE;
        end
      end
      S_NEWLINE: begin
        col_d = '0;
        if (row_q < 5'(VIS_ROWS - 1)) begin
          row_d   = row_q + 5'd1;
          state_d = S_CURSOR;
        end else begin
          offset_d = offset_q + 5'd1;
          state_d  = S_SCROLL;
        end
      end
      S_SCROLL: begin
        cnt_d   = '0;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (cnt_q == CW'(CLR_LAST)) state_d = S_CURSOR;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      S_BKSP: begin
        if (col_q == 7'd0) begin
          state_d = S_IDLE;
        end else begin
          col_d   = col_q - 7'd1;
          state_d = S_BK_GLYPH;
        end
      end
      S_BK_GLYPH: state_d = S_BK_COLOR;
      S_BK_COLOR: state_d = S_CURSOR;
      S_CURSOR:   state_d = S_IDLE;
      default:    state_d = S_INIT;
    endcase

    phys_d   = 5'(row_d + offset_d);
    init_idx = 13'(cnt_d - CW'(1));
    busy_d   = !(state_d == S_IDLE || state_d == S_FETCH);

    case (state_d)
      S_INIT: begin
        // init_idx = {col, row, phase}: c-major, r-minor, glyph before colour
        vga_en_d   = ~init_idx[0];
        color_en_d = init_idx[0];
        wraddr_d   = {20'b0, init_idx[12:1]};
        wdata_d    = init_idx[0] ? {5'b0, DEF_COLOR} : BLANK;
      end
      S_INIT_OFS, S_SCROLL: begin
        offset_en_d = 1'b1;
        wdata_d     = {3'b0, offset_d};
      end
      S_IDLE: key_rd_d = 1'b1;
      S_WR_CHAR, S_BK_GLYPH: begin
        vga_en_d = 1'b1;
        wraddr_d = {20'b0, col_d, phys_d};
        wdata_d  = (state_d == S_WR_CHAR) ? code_d : BLANK;
      end
      S_WR_COLOR, S_BK_COLOR: begin
        color_en_d = 1'b1;
        wraddr_d   = {20'b0, col_d, phys_d};
        wdata_d    = {5'b0, DEF_COLOR};
      end
      S_CLEAR: begin
        vga_en_d   = ~cnt_d[0];
        color_en_d = cnt_d[0];
        wraddr_d   = {20'b0, cnt_d[7:1], phys_d};
        wdata_d    = cnt_d[0] ? {5'b0, DEF_COLOR} : BLANK;
      end
      S_CURSOR: begin
        cursor_en_d   = 1'b1;
        cursor_data_d = {col_d, phys_d};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_console_ctrl.sv
// Scoreboard bench for console_ctrl: a terminal model predicts the write stream,
// a monitor checks every strobe the DUT produces against it.
module tb_console_ctrl;
  localparam int COLS = 70;
  localparam int VIS  = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_rd;
  logic [7:0]  key_data;
  logic        vga_en, vga_color_en, vga_offset_en, vga_cursor_en;
  logic [31:0] vga_wraddr;
  logic [7:0]  vga_wdata;
  logic [11:0] cursor_data;
  logic        busy;

  console_ctrl #(.COLS(COLS), .VIS_ROWS(VIS), .DEF_COLOR(3'b111)) dut (
    .clk(clk), .rst(rst), .key_rd(key_rd), .key_data(key_data),
    .vga_en(vga_en), .vga_color_en(vga_color_en), .vga_offset_en(vga_offset_en),
    .vga_cursor_en(vga_cursor_en), .vga_wraddr(vga_wraddr), .vga_wdata(vga_wdata),
    .cursor_data(cursor_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // kind: 0 glyph, 1 colour, 2 offset, 3 cursor; lat = cycles since key_rd, -1 = unchecked
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [11:0] data;
    int          lat;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo[$];
  int checks = 0;
  int errors = 0;
  int mcol, mrow, moff;

  // ---------------- terminal reference model ----------------
  function automatic int phys();
    return (mrow + moff) % 32;
  endfunction

  task automatic push_ev(input int kind, input int addr, input int data, input int lat);
    ev_t e;
    e.kind = kind; e.addr = 32'(addr); e.data = 12'(data); e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic m_cursor();
    push_ev(3, 0, mcol * 32 + phys(), -1);
  endtask

  task automatic m_newline();
    mcol = 0;
    if (mrow < VIS - 1) mrow++;
    else begin
      moff = (moff + 1) % 32;
      push_ev(2, 0, moff, -1);
      for (int c = 0; c < COLS; c++) begin
        push_ev(0, c * 32 + phys(), 8'h20, -1);
        push_ev(1, c * 32 + phys(), 7, -1);
      end
    end
  endtask

  task automatic m_key(input logic [7:0] k);
    int a;
    a = mcol * 32 + phys();
    if (k >= 8'h20 && k <= 8'h7E) begin
      push_ev(0, a, int'(k), 2);
      push_ev(1, a, 7, -1);
      if (mcol < COLS - 1) mcol++;
      else m_newline();
      m_cursor();
    end else if (k == 8'h0D || k == 8'h0A) begin
      m_newline();
      m_cursor();
    end else if (k == 8'h08 && mcol > 0) begin
      mcol--;
      a = mcol * 32 + phys();
      push_ev(0, a, 8'h20, 3);
      push_ev(1, a, 7, -1);
      m_cursor();
    end
  endtask

  task automatic m_init();
    mcol = 0; mrow = 0; moff = 0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < 32; r++) begin
        push_ev(0, c * 32 + r, 8'h20, -1);
        push_ev(1, c * 32 + r, 7, -1);
      end
    push_ev(2, 0, 0, -1);
    push_ev(3, 0, 0, -1);
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo.size() == 0 && !busy) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_%s: timed out with %0d events and %0d keys pending, expected 0",
               name, exp_q.size(), fifo.size());
    end
  endtask

  // ---------------- keyboard FIFO driver ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && key_rd) begin
        if (fifo.size() > 0) begin
          key_data = fifo.pop_front();
          m_key(key_data);
        end else begin
          key_data = 8'h00;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int cyc = 0;
    int last_rd = 0;
    forever begin
      int n, kind;
      bit ok;
      ev_t e;
      @(negedge clk);
      cyc++;
      n = int'(vga_en) + int'(vga_color_en) + int'(vga_offset_en) + int'(vga_cursor_en);
      if (rst) begin
        checks++;
        if (n != 0 || key_rd) begin
          errors++;
          $display("FAIL strobes_in_reset: got %0d strobes key_rd=%0b, expected none", n, key_rd);
        end
      end else begin
        if (key_rd) begin
          last_rd = cyc;
          checks++;
          if (busy) begin
            errors++;
            $display("FAIL pop_while_busy: key_rd=1 with busy=1, expected busy=0");
          end
        end
        if (n > 1) begin
          checks++; errors++;
          $display("FAIL multi_strobe: got %0d strobes in one cycle, expected 1", n);
        end else if (n == 1) begin
          kind = vga_en ? 0 : vga_color_en ? 1 : vga_offset_en ? 2 : 3;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: kind %0d addr 0x%0h data 0x%0h cur 0x%0h, expected none",
                     kind, vga_wraddr, vga_wdata, cursor_data);
          end else begin
            e = exp_q.pop_front();
            if (kind == 3)      ok = (cursor_data == e.data);
            else if (kind == 2) ok = (vga_wdata == e.data[7:0]);
            else                ok = (vga_wraddr == e.addr) && (vga_wdata == e.data[7:0]);
            ok = ok && (kind == e.kind) && (e.lat < 0 || cyc - last_rd == e.lat);
            if (!ok) begin
              errors++;
              $display("FAIL write: got kind %0d addr 0x%0h data 0x%0h cur 0x%0h lat %0d, expected kind %0d addr 0x%0h data 0x%0h lat %0d",
                       kind, vga_wraddr, vga_wdata, cursor_data, cyc - last_rd,
                       e.kind, e.addr, e.data, e.lat);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r, cnt, found;
    rst = 1'b1;
    key_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_wraddr", vga_wraddr, 32'd0);
    chk("reset_wdata", 32'(vga_wdata), 32'd0);
    chk("reset_cursor", 32'(cursor_data), 32'd0);
    m_init();
    rst = 1'b0;
    wait_drain(6000, "init");

    fifo.push_back(8'h41);
    wait_drain(100, "A");
    chk("cursor_A", 32'(cursor_data), 32'h020);

    for (int i = 0; i < 69; i++) fifo.push_back(8'($urandom_range(33, 126)));
    wait_drain(2000, "wrap");
    chk("cursor_wrap", 32'(cursor_data), 32'h001);

    fifo.push_back(8'h08);
    wait_drain(100, "bs_col0");
    chk("cursor_bs_col0", 32'(cursor_data), 32'h001);

    for (int i = 0; i < 5; i++) fifo.push_back(8'($urandom_range(32, 126)));
    fifo.push_back(8'h08);
    wait_drain(200, "bs_col5");
    chk("cursor_bs_col5", 32'(cursor_data), 32'h081);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      fifo.push_back(8'($urandom_range(32, 126)));
      else if (r < 80) fifo.push_back(r[0] ? 8'h0D : 8'h0A);
      else if (r < 90) fifo.push_back(8'h08);
      else if (r < 95) fifo.push_back(8'($urandom_range(1, 7)));
      else             fifo.push_back(8'($urandom_range(127, 255)));
    end
    wait_drain(30000, "random");

    // at least 35 scrolls, so the offset wraps past 31
    for (int i = 0; i < 64; i++) fifo.push_back(8'h0D);
    wait_drain(20000, "scrolls");
    chk("cursor_bottom", 32'(cursor_data), 32'((29 + moff) % 32));

    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (key_rd) cnt++;
    end
    chk("poll_rate", 32'(cnt), 32'd10);

    fifo.push_back(8'h0D);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (vga_offset_en) found = 1;
    end
    chk("scroll_seen", 32'(found), 32'd1);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_strobes", 32'({vga_en, vga_color_en, vga_offset_en, vga_cursor_en, key_rd}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    exp_q.delete();
    fifo.delete();
    key_data = 8'h00;
    m_init();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_drain(6000, "reinit");

    fifo.push_back(8'h42);
    wait_drain(100, "B");
    chk("cursor_B", 32'(cursor_data), 32'h020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
